mul_share_ctrl: RTL
===================

Name: mul_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one iterative 64x64 multiplier between NREQ requesters.
- The multiplier has a start/ready interface: operands A/B, one-cycle `start` pulse, `ready` high when the 128-bit product is valid.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block owns the multiplier's start, operand and reset-to-idle sequencing; exactly one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 64, operand width; product width is 2W.
- TIMEOUT, 1024, maximum WAIT cycles before the operation is aborted with an error; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_a  in  NREQ*W  operand A; requester i at bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot accept; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NREQ  one-hot; the result for requester i is on rsp_data.
- rsp_ready  in  NREQ  requester i accepts the result.
- rsp_data  out  2W  product (A*B, unsigned).
- rsp_err  out  1  valid with rsp_valid; 1 means watchdog abort and rsp_data=0.
- mul_a  out  W  multiplier operand A.
- mul_b  out  W  multiplier operand B.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_ready  in  1  multiplier done/idle.
- mul_out  in  2W  multiplier product.

Behaviour:
- Reset values:
  - state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - mul_start=0, mul_a=0, mul_b=0.
  - RR pointer last=NREQ-1, so requester 0 has first priority.
  - Watchdog counter=0.
- Reset is synchronous, dominates all inputs, and is valid in every state. An aborted operation produces no response. The multiplier shares rst.
- States: IDLE, START, GUARD, WAIT, RESP.
- IDLE:
  - Winner g is the first i with req_valid[i]=1, searching (last+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally in IDLE only; all other bits are 0.
  - On the handshake: latch req_a/req_b of g into mul_a/mul_b, record owner=g, set last=g, go to START.
  - If no req_valid, stay in IDLE with req_ready=0.
- START: mul_start=1 for exactly this cycle, then go to GUARD.
- GUARD: one cycle; mul_ready is ignored because the multiplier may still show stale ready. Clear the watchdog, then go to WAIT.
- WAIT:
  - If mul_ready=1: capture mul_out into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise the watchdog increments. If TIMEOUT!=0 and the count reaches TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid[owner]=1 and rsp_data/rsp_err are held stable until rsp_ready[owner]=1.
  - The handshake cycle is the last RESP cycle; the next state is IDLE and rsp_valid drops.
  - rsp_ready bits of non-owners are ignored.
- mul_a/mul_b are held stable from START until the next accept.
- Latency:
  - Accept at cycle T, mul_start at T+1, GUARD at T+2, WAIT from T+3.
  - mul_ready first seen at T+k gives rsp_valid from T+k+1.
  - Response handshake at R allows the earliest next accept at R+1.
- Requesters may change operands or drop req_valid before acceptance; operands are sampled only at the handshake.
- A requester whose response is pending may re-assert req_valid; it is arbitrated only after returning to IDLE.
- Round-robin guarantee: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 operations.
- No X propagation: outputs are deterministic from reset regardless of mul_out before the first completion.

Test Plan:
1. Single op: req 0, A=3, B=5, multiplier ready 10 cycles after start -> req_ready[0] pulse at T, mul_start at T+1 only, rsp_valid[0] with rsp_data=15, rsp_err=0, and accepted with rsp_ready=1.
2. Max operands: A=B=64'hFFFF_FFFF_FFFF_FFFF -> rsp_data=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
3. Contention: all 4 requesters valid continuously with random operands -> grant order 0,1,2,3,0,1; every rsp_data matches the golden product, one-hot rsp_valid each time.
4. Backpressure: rsp_ready[2] held low 20 cycles -> rsp_valid[2] and rsp_data stable for the whole period; no new req_ready until 1 cycle after the handshake.
5. Watchdog: TIMEOUT=16, mul_ready tied low after start -> rsp_valid at accept+19 with rsp_err=1, rsp_data=0; the next request is still serviced.
6. Reset mid-WAIT: rst=1 for one cycle during WAIT -> next cycle all outputs zero, state IDLE, no response for the aborted op, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
//   Round-robin arbiter and sequencer that shares one iterative W x W
//   multiplier between NREQ requesters. Only one multiply is in flight at a
//   time: accept -> START (one-cycle mul_start) -> GUARD -> WAIT -> RESP.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready one-hot, IDLE only)
//   req_a, req_b      packed operands, requester i at [i*W +: W]
//   rsp_valid/ready   per-requester response handshake (valid one-hot)
//   rsp_data, rsp_err product (2W bits); err=1 means watchdog abort, data=0
//   mul_a, mul_b      operands to the shared multiplier, held until next accept
//   mul_start         one-cycle start pulse
//   mul_ready, mul_out multiplier done flag and product
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand width
//   TIMEOUT  max WAIT cycles before abort; 0 disables the watchdog
module mul_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [2*W-1:0]      rsp_data,
  output logic                rsp_err,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  output logic                mul_start,
  input  logic                mul_ready,
  input  logic [2*W-1:0]      mul_out
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant;
  logic            grant_found;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expire;

  // Round-robin search: first valid requester strictly after the last winner.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    idx         = 0;
    grant       = last;
    grant_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!grant_found && req_valid[IW'(idx)]) begin
        grant       = IW'(idx);
        grant_found = 1'b1;
      end
    end
  end

  // Abort on the cycle the count would reach TIMEOUT without mul_ready.
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state)
      S_IDLE: begin
        // A granted requester is valid, so req_ready implies the handshake.
        if (grant_found) begin
          req_ready[grant] = 1'b1;
          state_nx         = S_START;
        end
      end
      S_START: begin
        mul_start = 1'b1;
        state_nx  = S_GUARD;
      end
      // The multiplier may still present last operation's ready here.
      S_GUARD: state_nx = S_WAIT;
      S_WAIT: begin
        if (mul_ready || wd_expire) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Reset dominates: no handshake can complete during a reset cycle.
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
      mul_start = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, datapath included, is reset so outputs are
      // deterministic before the first completion (no X from mul_out).
      state    <= S_IDLE;
      last     <= IW'(NREQ - 1);
      owner    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            mul_a <= req_a[int'(grant)*W +: W];
            mul_b <= req_b[int'(grant)*W +: W];
            owner <= grant;
            last  <= grant;
          end
        end
        S_GUARD: wd_cnt <= '0;
        S_WAIT: begin
          if (mul_ready) begin
            rsp_data <= mul_out;
            rsp_err  <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
